// File: rtl/mm_addr_sequencer.sv
// mm_addr_sequencer: address generator for the 8-port matmul data memory.
// Walks C = A x B in groups of LANES output elements; each step presents one
// A/B/C address per lane plus lane-valid and last-k flags.
// Optional feature macro: MM_DIM_CHECK_EN (dimension/size check with ERR state).
module mm_addr_sequencer #(
    parameter int unsigned LANES     = 8,
    parameter int unsigned AW        = 16,
    parameter int unsigned MEM_DEPTH = 10501
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [AW-1:0]       dim_ra,
    input  logic [AW-1:0]       dim_ca,
    input  logic [AW-1:0]       dim_rb,
    input  logic [AW-1:0]       dim_cb,
    output logic                step_valid,
    input  logic                step_ready,
    output logic [LANES*AW-1:0] addr_a,
    output logic [LANES*AW-1:0] addr_b,
    output logic [LANES*AW-1:0] addr_c,
    output logic [LANES-1:0]    lane_valid,
    output logic                last_k,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned EW     = AW + 1;   // element index needs one guard bit
    localparam int unsigned A_BASE = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] ra_q, ca_q, rb_q, cb_q;
    logic [AW-1:0] ra_d, ca_d, rb_d, cb_d;
    logic [AW-1:0] base_b_q, base_c_q, n_q;
    logic [AW-1:0] base_b_d, base_c_d, n_d;
    logic [EW-1:0] e_q, e_d;
    logic [AW-1:0] k_q, k_d, kcb_q, kcb_d;

    // Per-lane (i,j) position and the row offsets i*CA and i*CB.
    logic [AW-1:0] i_q [LANES];
    logic [AW-1:0] j_q [LANES];
    logic [AW-1:0] rowa_q [LANES];
    logic [AW-1:0] rowc_q [LANES];
    logic [AW-1:0] i_d [LANES];
    logic [AW-1:0] j_d [LANES];
    logic [AW-1:0] rowa_d [LANES];
    logic [AW-1:0] rowc_d [LANES];

    logic                step_valid_q, step_valid_d;
    logic [LANES*AW-1:0] addr_a_q, addr_a_d;
    logic [LANES*AW-1:0] addr_b_q, addr_b_d;
    logic [LANES*AW-1:0] addr_c_q, addr_c_d;
    logic [LANES-1:0]    lane_valid_q, lane_valid_d;
    logic                last_k_q, last_k_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [AW-1:0] base_b_c, base_c_c, n_c;
    logic          consume_c;

    // Layout bases and element count from the latched dims (modulo 2^AW).
    assign base_b_c  = AW'(A_BASE) + AW'(ra_q * ca_q);
    assign base_c_c  = base_b_c + AW'(rb_q * cb_q);
    assign n_c       = AW'(ra_q * cb_q);
    assign consume_c = step_valid_q & step_ready;

`ifdef MM_DIM_CHECK_EN
    localparam int unsigned FW = 2 * AW + 2;
    logic [FW-1:0] need_c;
    logic          dim_bad_c;
    logic          err_q, err_d;

    // Untruncated end-of-C address for the memory-depth check.
    assign need_c    = FW'(A_BASE) + FW'(ra_q) * FW'(ca_q) + FW'(rb_q) * FW'(cb_q)
                     + FW'(ra_q) * FW'(cb_q);
    assign dim_bad_c = (ca_q != rb_q) || (need_c > FW'(MEM_DEPTH));
`endif

    // Advance one lane's (i,j) by inc elements with row wrap; inc <= LANES, cb >= 1.
    function automatic void lane_adv(
        input  logic [AW-1:0] i_in,
        input  logic [AW-1:0] j_in,
        input  logic [AW-1:0] ra_in,
        input  logic [AW-1:0] rc_in,
        input  logic [AW:0]   inc,
        input  logic [AW-1:0] ca,
        input  logic [AW-1:0] cb,
        output logic [AW-1:0] i_out,
        output logic [AW-1:0] j_out,
        output logic [AW-1:0] ra_out,
        output logic [AW-1:0] rc_out
    );
        logic [AW:0] j_t;
        j_t    = {1'b0, j_in} + inc;
        i_out  = i_in;
        ra_out = ra_in;
        rc_out = rc_in;
        for (int w = 0; w < LANES; w++) begin
            if (j_t >= {1'b0, cb}) begin
                j_t    = j_t - {1'b0, cb};
                i_out  = i_out + AW'(1);
                ra_out = ra_out + ca;
                rc_out = rc_out + cb;
            end
        end
        j_out = j_t[AW-1:0];
    endfunction

    // Next-state, position update and next registered outputs.
    always_comb begin
        state_d      = state_q;
        ra_d         = ra_q;
        ca_d         = ca_q;
        rb_d         = rb_q;
        cb_d         = cb_q;
        base_b_d     = base_b_q;
        base_c_d     = base_c_q;
        n_d          = n_q;
        e_d          = e_q;
        k_d          = k_q;
        kcb_d        = kcb_q;
        i_d          = i_q;
        j_d          = j_q;
        rowa_d       = rowa_q;
        rowc_d       = rowc_q;
        step_valid_d = 1'b0;
        lane_valid_d = '0;
        addr_a_d     = '0;
        addr_b_d     = '0;
        addr_c_d     = '0;
        last_k_d     = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef MM_DIM_CHECK_EN
        err_d        = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d    = dim_ra;
                    ca_d    = dim_ca;
                    rb_d    = dim_rb;
                    cb_d    = dim_cb;
`ifdef MM_DIM_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                base_b_d = base_b_c;
                base_c_d = base_c_c;
                n_d      = n_c;
                e_d      = '0;
                k_d      = '0;
                kcb_d    = '0;
                for (int l = 0; l < LANES; l++) begin
                    lane_adv('0, '0, '0, '0, (AW+1)'(l), ca_q, cb_q,
                             i_d[l], j_d[l], rowa_d[l], rowc_d[l]);
                end
                if (n_c == '0 || ca_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
`ifdef MM_DIM_CHECK_EN
                if (dim_bad_c) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_ISSUE: begin
                if (consume_c) begin
                    if (!last_k_q) begin
                        k_d   = k_q + AW'(1);
                        kcb_d = kcb_q + cb_q;
                    end else begin
                        k_d   = '0;
                        kcb_d = '0;
                        e_d   = e_q + EW'(LANES);
                        for (int l = 0; l < LANES; l++) begin
                            lane_adv(i_q[l], j_q[l], rowa_q[l], rowc_q[l],
                                     (AW+1)'(LANES), ca_q, cb_q,
                                     i_d[l], j_d[l], rowa_d[l], rowc_d[l]);
                        end
                        if (e_q + EW'(LANES) >= {1'b0, n_q}) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

`ifdef MM_DIM_CHECK_EN
        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end
`endif
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);

        if (state_d == ST_ISSUE) begin
            step_valid_d = 1'b1;
            last_k_d     = (k_d == AW'(ca_q - AW'(1)));
            for (int l = 0; l < LANES; l++) begin
                if (e_d + EW'(l) < {1'b0, n_d}) begin
                    lane_valid_d[l]        = 1'b1;
                    addr_a_d[l*AW +: AW]   = AW'(A_BASE) + rowa_d[l] + k_d;
                    addr_b_d[l*AW +: AW]   = base_b_d + kcb_d + j_d[l];
                    addr_c_d[l*AW +: AW]   = base_c_d + rowc_d[l] + j_d[l];
                end
            end
        end
    end

    // State, position and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ra_q         <= '0;
            ca_q         <= '0;
            rb_q         <= '0;
            cb_q         <= '0;
            base_b_q     <= '0;
            base_c_q     <= '0;
            n_q          <= '0;
            e_q          <= '0;
            k_q          <= '0;
            kcb_q        <= '0;
            for (int l = 0; l < LANES; l++) begin
                i_q[l]    <= '0;
                j_q[l]    <= '0;
                rowa_q[l] <= '0;
                rowc_q[l] <= '0;
            end
            step_valid_q <= 1'b0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            addr_c_q     <= '0;
            lane_valid_q <= '0;
            last_k_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ra_q         <= ra_d;
            ca_q         <= ca_d;
            rb_q         <= rb_d;
            cb_q         <= cb_d;
            base_b_q     <= base_b_d;
            base_c_q     <= base_c_d;
            n_q          <= n_d;
            e_q          <= e_d;
            k_q          <= k_d;
            kcb_q        <= kcb_d;
            i_q          <= i_d;
            j_q          <= j_d;
            rowa_q       <= rowa_d;
            rowc_q       <= rowc_d;
            step_valid_q <= step_valid_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            addr_c_q     <= addr_c_d;
            lane_valid_q <= lane_valid_d;
            last_k_q     <= last_k_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef MM_DIM_CHECK_EN
    // Sticky error flag, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign step_valid = step_valid_q;
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign addr_c     = addr_c_q;
    assign lane_valid = lane_valid_q;
    assign last_k     = last_k_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mm_addr_sequencer.sv
// Directed testbench for mm_addr_sequencer with hand-computed step addresses.
module tb_mm_addr_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned L  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   dim_ra, dim_ca, dim_rb, dim_cb;
    logic            step_valid;
    logic            step_ready;
    logic [L*AW-1:0] addr_a, addr_b, addr_c;
    logic [L-1:0]    lane_valid;
    logic            last_k;
    logic            busy;
    logic            done;
    logic            err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mm_addr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dim_ra     (dim_ra),
        .dim_ca     (dim_ca),
        .dim_rb     (dim_rb),
        .dim_cb     (dim_cb),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .addr_c     (addr_c),
        .lane_valid (lane_valid),
        .last_k     (last_k),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int ra, input int ca, input int rb, input int cb);
        dim_ra = AW'(ra);
        dim_ca = AW'(ca);
        dim_rb = AW'(rb);
        dim_cb = AW'(cb);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic chk_step(input string tag, input logic [7:0] lv, input logic [127:0] a,
                            input logic [127:0] b, input logic [127:0] c, input logic lk);
        check_val({tag, "_valid"}, 128'(step_valid), 128'(1));
        check_val({tag, "_lv"},    128'(lane_valid), 128'(lv));
        check_val({tag, "_a"},     addr_a, a);
        check_val({tag, "_b"},     addr_b, b);
        check_val({tag, "_c"},     addr_c, c);
        check_val({tag, "_lastk"}, 128'(last_k), 128'(lk));
    endtask

    task automatic chk_done(input string tag);
        check_val({tag, "_done"},  128'(done), 128'(1));
        check_val({tag, "_sv"},    128'(step_valid), 128'(0));
        tick();
        check_val({tag, "_done1"}, 128'(done), 128'(0));
        check_val({tag, "_idle"},  128'(busy), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        step_ready = 1'b0;
        dim_ra = '0; dim_ca = '0; dim_rb = '0; dim_cb = '0;
        tick();
        tick();
        check_val("rst_sv",   128'(step_valid), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_done", 128'(done), 128'(0));
        check_val("rst_err",  128'(err), 128'(0));
        check_val("rst_a",    addr_a, 128'(0));
        check_val("rst_lv",   128'(lane_valid), 128'(0));
        rst_n = 1'b1;
        tick();

        // 2x2 * 2x2 with ready held high
        step_ready = 1'b1;
        start_run(2, 2, 2, 2);
        check_val("t1_chk_busy", 128'(busy), 128'(1));
        check_val("t1_chk_sv",   128'(step_valid), 128'(0));
        tick();
        chk_step("t1s0", 8'h0F, pk(5,5,7,7,0,0,0,0), pk(9,10,9,10,0,0,0,0),
                 pk(13,14,15,16,0,0,0,0), 1'b0);
        tick();
        chk_step("t1s1", 8'h0F, pk(6,6,8,8,0,0,0,0), pk(11,12,11,12,0,0,0,0),
                 pk(13,14,15,16,0,0,0,0), 1'b1);
        tick();
        chk_done("t1");

        // 3x1 * 1x3: two groups, second has one valid lane
        start_run(3, 1, 1, 3);
        tick();
        chk_step("t2s0", 8'hFF, pk(5,5,5,6,6,6,7,7), pk(8,9,10,8,9,10,8,9),
                 pk(11,12,13,14,15,16,17,18), 1'b1);
        tick();
        chk_step("t2s1", 8'h01, pk(7,0,0,0,0,0,0,0), pk(10,0,0,0,0,0,0,0),
                 pk(19,0,0,0,0,0,0,0), 1'b1);
        tick();
        chk_done("t2");

        // Backpressure: ready low for 5 cycles freezes the first step
        step_ready = 1'b0;
        start_run(2, 2, 2, 2);
        tick();
        for (int s = 0; s < 5; s++) begin
            chk_step("t3hold", 8'h0F, pk(5,5,7,7,0,0,0,0), pk(9,10,9,10,0,0,0,0),
                     pk(13,14,15,16,0,0,0,0), 1'b0);
            tick();
        end
        step_ready = 1'b1;
        chk_step("t3s0", 8'h0F, pk(5,5,7,7,0,0,0,0), pk(9,10,9,10,0,0,0,0),
                 pk(13,14,15,16,0,0,0,0), 1'b0);
        tick();
        chk_step("t3s1", 8'h0F, pk(6,6,8,8,0,0,0,0), pk(11,12,11,12,0,0,0,0),
                 pk(13,14,15,16,0,0,0,0), 1'b1);
        tick();
        chk_done("t3");

        // Start while busy with different dims is ignored
        step_ready = 1'b0;
        start_run(2, 2, 2, 2);
        tick();
        start_run(3, 1, 1, 3);
        chk_step("t4s0", 8'h0F, pk(5,5,7,7,0,0,0,0), pk(9,10,9,10,0,0,0,0),
                 pk(13,14,15,16,0,0,0,0), 1'b0);
        step_ready = 1'b1;
        tick();
        chk_step("t4s1", 8'h0F, pk(6,6,8,8,0,0,0,0), pk(11,12,11,12,0,0,0,0),
                 pk(13,14,15,16,0,0,0,0), 1'b1);
        tick();
        chk_done("t4");

        // Asynchronous reset mid-run, then a fresh run from the beginning
        start_run(3, 1, 1, 3);
        tick();
        chk_step("t5s0", 8'hFF, pk(5,5,5,6,6,6,7,7), pk(8,9,10,8,9,10,8,9),
                 pk(11,12,13,14,15,16,17,18), 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_sv",   128'(step_valid), 128'(0));
        check_val("t5_rst_busy", 128'(busy), 128'(0));
        check_val("t5_rst_a",    addr_a, 128'(0));
        check_val("t5_rst_lv",   128'(lane_valid), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_val("t5_nodone", 128'(done), 128'(0));
        check_val("t5_idle",   128'(busy), 128'(0));
        start_run(2, 2, 2, 2);
        tick();
        chk_step("t5r0", 8'h0F, pk(5,5,7,7,0,0,0,0), pk(9,10,9,10,0,0,0,0),
                 pk(13,14,15,16,0,0,0,0), 1'b0);
        tick();
        chk_step("t5r1", 8'h0F, pk(6,6,8,8,0,0,0,0), pk(11,12,11,12,0,0,0,0),
                 pk(13,14,15,16,0,0,0,0), 1'b1);
        tick();
        chk_done("t5");

        // Mismatched inner dims 2,3,2,2
        start_run(2, 3, 2, 2);
`ifdef MM_DIM_CHECK_EN
        tick();
        check_val("t6_err",   128'(err), 128'(1));
        check_val("t6_sv",    128'(step_valid), 128'(0));
        check_val("t6_busy",  128'(busy), 128'(1));
        check_val("t6_done",  128'(done), 128'(0));
        tick();
        check_val("t6_err_h", 128'(err), 128'(1));
        check_val("t6_idle",  128'(busy), 128'(0));
        check_val("t6_done1", 128'(done), 128'(0));
        check_val("t6_sv1",   128'(step_valid), 128'(0));
`else
        tick();
        chk_step("t6k0", 8'h0F, pk(5,5,8,8,0,0,0,0), pk(11,12,11,12,0,0,0,0),
                 pk(15,16,17,18,0,0,0,0), 1'b0);
        tick();
        chk_step("t6k1", 8'h0F, pk(6,6,9,9,0,0,0,0), pk(13,14,13,14,0,0,0,0),
                 pk(15,16,17,18,0,0,0,0), 1'b0);
        tick();
        chk_step("t6k2", 8'h0F, pk(7,7,10,10,0,0,0,0), pk(15,16,15,16,0,0,0,0),
                 pk(15,16,17,18,0,0,0,0), 1'b1);
        tick();
        chk_done("t6");
        check_val("t6_err0", 128'(err), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
